store_buffer: RTL and testbench

//   Write buffer between the MEM stage and the data memory. Queues stores (WD/SB/SH)

---
 rtl/store_buffer_pkg.sv | 26 ++
 rtl/store_buffer_match.sv | 37 +++
 rtl/store_buffer.sv | 148 ++++++++++++++
 tb/tb_store_buffer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared memory-op encodings and store-buffer defaults.
// STB_FWD_EN (optional macro) enables load forwarding from pending word stores.
package store_buffer_pkg;

    localparam logic [2:0] DM_OP_WD = 3'd0;
    localparam logic [2:0] DM_OP_SB = 3'd1;
    localparam logic [2:0] DM_OP_SH = 3'd2;
    localparam logic [2:0] DM_OP_BS = 3'd3;
    localparam logic [2:0] DM_OP_BZ = 3'd4;
    localparam logic [2:0] DM_OP_HS = 3'd5;
    localparam logic [2:0] DM_OP_HZ = 3'd6;

    localparam int SB_DEPTH = 4;

    // Byte/half lanes live in the top bits of the word, as the store path delivers them.
    function automatic logic [31:0] dm_load_ext(input logic [2:0] op, input logic [31:0] d);
        case (op)
            DM_OP_BS: return {{24{d[31]}}, d[31:24]};
            DM_OP_BZ: return {24'h0, d[31:24]};
            DM_OP_HS: return {{16{d[31]}}, d[31:16]};
            DM_OP_HZ: return {16'h0, d[31:16]};
            default:  return d;
        endcase
    endfunction

endpackage

// File: rtl/store_buffer_match.sv
// Age-ordered comparator: finds the youngest valid store entry whose word address
// equals the load word address.
module sb_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTRW  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][29:0] word_i,
    input  logic [DEPTH-1:0][2:0]  op_i,
    input  logic [PTRW-1:0]        head_i,
    input  logic [PTRW:0]          count_i,
    input  logic [29:0]            ld_word_i,
    output logic                   hit_o,
    output logic [PTRW-1:0]        idx_o,
    output logic [2:0]             op_o
);

    logic [PTRW-1:0] slot;

    // Walk oldest to youngest so a later (younger) match overrides an earlier one.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        op_o  = '0;
        slot  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head_i + PTRW'(k);
            if (((PTRW+1)'(k) < count_i) && (word_i[slot] == ld_word_i)) begin
                hit_o = 1'b1;
                idx_o = slot;
                op_o  = op_i[slot];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between MEM stage and data memory: queues stores, drains them when the
// port is idle, and resolves loads against pending stores. Forwarding under STB_FWD_EN.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTRW  = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [2:0]  st_op,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    input  logic [2:0]  ld_op,
    output logic        ld_stall,
    output logic        ld_fwd_hit,
    output logic [31:0] ld_fwd_data,
    output logic        dm_w,
    output logic        dm_r,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [2:0]  dm_op,
    output logic        sb_empty
);

    localparam logic [PTRW:0] CNT_FULL = (PTRW+1)'(DEPTH);

    logic [DEPTH-1:0][31:0] addr_q;
    logic [DEPTH-1:0][31:0] data_q;
    logic [DEPTH-1:0][2:0]  op_q;
    logic [DEPTH-1:0][29:0] ent_word;

    logic [PTRW-1:0] head_q, head_d;
    logic [PTRW-1:0] tail_q, tail_d;
    logic [PTRW:0]   count_q, count_d;

    logic            full;
    logic            push;
    logic            drain;
    logic            load_on_port;
    logic            fwd_ok;
    logic            m_hit;
    logic [PTRW-1:0] m_idx;
    logic [2:0]      m_op;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_word[i] = addr_q[i][31:2];
        end
    end

    sb_match #(
        .DEPTH (DEPTH),
        .PTRW  (PTRW)
    ) u_match (
        .word_i    (ent_word),
        .op_i      (op_q),
        .head_i    (head_q),
        .count_i   (count_q),
        .ld_word_i (ld_addr[31:2]),
        .hit_o     (m_hit),
        .idx_o     (m_idx),
        .op_o      (m_op)
    );

    assign full     = (count_q == CNT_FULL);
    assign st_ready = !rst && !full;
    assign push     = st_valid && st_ready;
    assign sb_empty = (count_q == '0);

`ifdef STB_FWD_EN
    assign fwd_ok      = m_hit && (m_op == DM_OP_WD);
    // A full buffer stalls the load even on a word hit so the drain keeps making progress.
    assign ld_fwd_hit  = !rst && ld_req && !full && fwd_ok;
    assign ld_fwd_data = ld_fwd_hit ? dm_load_ext(ld_op, data_q[m_idx]) : 32'h0;
`else
    logic unused_match;
    assign fwd_ok       = 1'b0;
    assign ld_fwd_hit   = 1'b0;
    assign ld_fwd_data  = 32'h0;
    assign unused_match = ^{m_idx, m_op};
`endif

    assign ld_stall     = !rst && ld_req && (full || (m_hit && !fwd_ok));
    assign load_on_port = !rst && ld_req && !ld_stall && !ld_fwd_hit;
    assign drain        = !rst && (count_q != '0) && !load_on_port;

    always_comb begin
        dm_w     = 1'b0;
        dm_r     = 1'b0;
        dm_addr  = 32'h0;
        dm_wdata = 32'h0;
        dm_op    = 3'h0;
        if (load_on_port) begin
            dm_r    = 1'b1;
            dm_addr = ld_addr;
            dm_op   = ld_op;
        end else if (drain) begin
            dm_w     = 1'b1;
            dm_addr  = addr_q[head_q];
            dm_wdata = data_q[head_q];
            dm_op    = op_q[head_q];
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        if (drain) begin
            head_d = head_q + 1'b1;
        end
        case ({push, drain})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload needs no reset: only slots inside [head, head+count) are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= st_addr;
            data_q[tail_q] <= st_data;
            op_q[tail_q]   <= st_op;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int DEPTH = SB_DEPTH;

`ifdef STB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  op;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_op;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic [2:0]  ld_op;
    logic        ld_stall;
    logic        ld_fwd_hit;
    logic [31:0] ld_fwd_data;
    logic        dm_w;
    logic        dm_r;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [2:0]  dm_op;
    logic        sb_empty;

    int checks = 0;
    int errors = 0;
    ent_t q[$];

    logic        a_st_ready, a_stall, a_fwd, a_dm_w, a_dm_r, a_empty;
    logic [31:0] a_fdata, a_addr, a_wdata;
    logic [2:0]  a_op;

    logic [2:0] ld_ops[5] = '{DM_OP_BS, DM_OP_BZ, DM_OP_HS, DM_OP_HZ, DM_OP_WD};
    logic [2:0] st_ops[3] = '{DM_OP_WD, DM_OP_SB, DM_OP_SH};

    store_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .st_valid    (st_valid),
        .st_ready    (st_ready),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_op       (st_op),
        .ld_req      (ld_req),
        .ld_addr     (ld_addr),
        .ld_op       (ld_op),
        .ld_stall    (ld_stall),
        .ld_fwd_hit  (ld_fwd_hit),
        .ld_fwd_data (ld_fwd_data),
        .dm_w        (dm_w),
        .dm_r        (dm_r),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_op       (dm_op),
        .sb_empty    (sb_empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_ext(input logic [2:0] op, input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[31:24];
        h = d[31:16];
        if (op == DM_OP_BS) return 32'($signed(b));
        if (op == DM_OP_BZ) return 32'(b);
        if (op == DM_OP_HS) return 32'($signed(h));
        if (op == DM_OP_HZ) return 32'(h);
        return d;
    endfunction

    // Compare at the negedge, then advance the model at the following posedge.
    task automatic step();
        bit          full, hit, fwd_ok, e_fwd, e_stall, e_load, e_drain, e_push;
        logic [31:0] hdata, e_addr, e_wdata, e_fdata;
        logic [2:0]  hop, e_op;
        ent_t        e;
        @(negedge clk);
        full  = (q.size() == DEPTH);
        hit   = 1'b0;
        hop   = '0;
        hdata = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (!hit && q[i].addr[31:2] == ld_addr[31:2]) begin
                hit   = 1'b1;
                hop   = q[i].op;
                hdata = q[i].data;
            end
        end
        fwd_ok  = FWD && hit && (hop == DM_OP_WD);
        e_fwd   = !rst && ld_req && !full && fwd_ok;
        e_stall = !rst && ld_req && (full || (hit && !fwd_ok));
        e_load  = !rst && ld_req && !e_stall && !e_fwd;
        e_drain = !rst && (q.size() != 0) && !e_load;
        e_push  = !rst && st_valid && !full;
        e_fdata = e_fwd ? ref_ext(ld_op, hdata) : 32'h0;
        e_addr  = e_load ? ld_addr : (e_drain ? q[0].addr : 32'h0);
        e_wdata = e_drain && !e_load ? q[0].data : 32'h0;
        e_op    = e_load ? ld_op : (e_drain ? q[0].op : 3'h0);

        chk("st_ready", 32'(st_ready), 32'(!rst && !full));
        chk("ld_stall", 32'(ld_stall), 32'(e_stall));
        chk("ld_fwd_hit", 32'(ld_fwd_hit), 32'(e_fwd));
        chk("ld_fwd_data", ld_fwd_data, e_fdata);
        chk("dm_r", 32'(dm_r), 32'(e_load));
        chk("dm_w", 32'(dm_w), 32'(e_drain));
        chk("dm_addr", dm_addr, e_addr);
        chk("dm_wdata", dm_wdata, e_wdata);
        chk("dm_op", 32'(dm_op), 32'(e_op));
        chk("sb_empty", 32'(sb_empty), 32'(q.size() == 0));

        a_st_ready = st_ready; a_stall = ld_stall; a_fwd = ld_fwd_hit; a_fdata = ld_fwd_data;
        a_dm_w = dm_w; a_dm_r = dm_r; a_addr = dm_addr; a_wdata = dm_wdata; a_op = dm_op;
        a_empty = sb_empty;

        e.addr = st_addr;
        e.data = st_data;
        e.op   = st_op;
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            if (e_drain) void'(q.pop_front());
            if (e_push) q.push_back(e);
        end
        #1;
    endtask

    task automatic set_st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
        st_valid = 1'b1; st_addr = a; st_data = d; st_op = op;
    endtask

    task automatic set_ld(input logic [31:0] a, input logic [2:0] op);
        ld_req = 1'b1; ld_addr = a; ld_op = op;
    endtask

    task automatic quiet();
        st_valid = 1'b0; st_addr = '0; st_data = '0; st_op = '0;
        ld_req = 1'b0; ld_addr = '0; ld_op = '0;
    endtask

    initial begin
        rst = 1'b1;
        quiet();
        @(posedge clk);
        #1;
        step();
        chk("rst_st_ready", 32'(a_st_ready), 32'd0);
        chk("rst_dm_w", 32'(a_dm_w), 32'd0);
        rst = 1'b0;

        // Single word store drains the cycle after it is accepted.
        set_st(32'h10, 32'hAABBCCDD, DM_OP_WD);
        step();
        chk("t1_empty_on_push", 32'(a_empty), 32'd1);
        quiet();
        step();
        chk("t1_dm_w", 32'(a_dm_w), 32'd1);
        chk("t1_dm_addr", a_addr, 32'h10);
        chk("t1_dm_wdata", a_wdata, 32'hAABBCCDD);
        step();
        chk("t1_empty_after", 32'(a_empty), 32'd1);

        // Fill with a non-matching load hogging the port; full forces a drain.
        set_ld(32'h900, DM_OP_WD);
        for (int i = 0; i < 4; i++) begin
            set_st(32'h40 + 32'(4 * i), 32'h100 + 32'(i), DM_OP_WD);
            step();
            chk("t2_ready_fill", 32'(a_st_ready), 32'd1);
        end
        set_st(32'h50, 32'h104, DM_OP_WD);
        step();
        chk("t2_ready_full", 32'(a_st_ready), 32'd0);
        chk("t2_stall_full", 32'(a_stall), 32'd1);
        chk("t2_drain_full", 32'(a_dm_w), 32'd1);
        chk("t2_drain_addr", a_addr, 32'h40);
        st_valid = 1'b0;
        step();
        chk("t2_load_back", 32'(a_dm_r), 32'd1);
        quiet();
        for (int i = 1; i < 4; i++) begin
            step();
            chk("t2_order_addr", a_addr, 32'h40 + 32'(4 * i));
            chk("t2_order_data", a_wdata, 32'h100 + 32'(i));
        end
        step();
        chk("t2_empty", 32'(a_empty), 32'd1);

        // Word store then byte load to the same word.
        set_st(32'h20, 32'h80FF0000, DM_OP_WD);
        step();
        quiet();
        set_ld(32'h20, DM_OP_BS);
        step();
        if (FWD) begin
            chk("t3_fwd_hit", 32'(a_fwd), 32'd1);
            chk("t3_fwd_data", a_fdata, 32'hFFFFFF80);
            chk("t3_fwd_nostall", 32'(a_stall), 32'd0);
        end else begin
            chk("t3_stall", 32'(a_stall), 32'd1);
            chk("t3_fwd_tied", 32'(a_fwd), 32'd0);
        end
        chk("t3_drain", 32'(a_dm_w), 32'd1);
        step();
        chk("t3_read", 32'(a_dm_r), 32'd1);
        chk("t3_read_addr", a_addr, 32'h20);
        quiet();

        // Byte store pending: word load must wait for it.
        set_st(32'h24, 32'hAB000000, DM_OP_SB);
        step();
        quiet();
        set_ld(32'h24, DM_OP_WD);
        step();
        chk("t4_stall", 32'(a_stall), 32'd1);
        chk("t4_drain_op", 32'(a_op), 32'(DM_OP_SB));
        step();
        chk("t4_read", 32'(a_dm_r), 32'd1);
        chk("t4_nostall", 32'(a_stall), 32'd0);
        quiet();

        // Two word stores to one address: the younger one is forwarded.
        set_ld(32'h900, DM_OP_WD);
        set_st(32'h30, 32'h1, DM_OP_WD);
        step();
        set_st(32'h30, 32'h2, DM_OP_WD);
        step();
        st_valid = 1'b0;
        set_ld(32'h30, DM_OP_WD);
        step();
        if (FWD) begin
            chk("t5_fwd_data", a_fdata, 32'h2);
            chk("t5_drain_old", a_wdata, 32'h1);
        end else begin
            chk("t5_stall", 32'(a_stall), 32'd1);
        end
        quiet();
        repeat (3) step();

        // Reset in the middle of a drain discards the remaining stores.
        set_ld(32'h900, DM_OP_WD);
        for (int i = 0; i < 3; i++) begin
            set_st(32'h60 + 32'(4 * i), 32'h600 + 32'(i), DM_OP_SH);
            step();
        end
        quiet();
        step();
        chk("t6_drain", 32'(a_dm_w), 32'd1);
        chk("t6_drain_addr", a_addr, 32'h60);
        rst = 1'b1;
        set_ld(32'h64, DM_OP_WD);
        step();
        chk("t6_rst_dm_w", 32'(a_dm_w), 32'd0);
        chk("t6_rst_stall", 32'(a_stall), 32'd0);
        chk("t6_rst_dm_r", 32'(a_dm_r), 32'd0);
        rst = 1'b0;
        quiet();
        step();
        chk("t6_empty", 32'(a_empty), 32'd1);
        chk("t6_no_drain", 32'(a_dm_w), 32'd0);

        // Randomized traffic over a small address window to provoke matches.
        for (int n = 0; n < 4000; n++) begin
            rst      = ($urandom_range(0, 149) == 0);
            st_valid = ($urandom_range(0, 99) < 55);
            st_addr  = 32'h200 + 32'($urandom_range(0, 15));
            st_data  = $urandom;
            st_op    = st_ops[$urandom_range(0, 2)];
            ld_req   = ($urandom_range(0, 99) < 50);
            ld_addr  = 32'h200 + 32'($urandom_range(0, 19));
            ld_op    = ld_ops[$urandom_range(0, 4)];
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
